// File: rtl/branch_history_table.sv
// Direct-mapped table of 2-bit saturating branch predictors.
// Fetch reads a prediction combinationally; the resolve stage writes back
// outcomes. The table sweeps itself to INIT_STATE after reset or clear and
// keeps a saturating count of mispredicted updates.
module branch_history_table #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_i,
  input  logic [31:0]           pred_pc_i,
  output logic                  pred_taken_o,
  output logic [1:0]            pred_cnt_o,
  input  logic                  upd_valid_i,
  input  logic [31:0]           upd_pc_i,
  input  logic                  upd_taken_i,
  output logic                  ready_o,
  output logic [STAT_WIDTH-1:0] mispred_cnt_o
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;

  typedef enum logic {StInit, StReady} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [STAT_WIDTH-1:0] mis_q, mis_d;
  logic [1:0]            table_q [Entries];

  logic [INDEX_BITS-1:0] pred_idx, upd_idx;
  logic                  upd_apply, upd_correct;
  logic [1:0]            upd_cur, upd_new;

  assign pred_idx  = pred_pc_i[INDEX_BITS+1:2];
  assign upd_idx   = upd_pc_i[INDEX_BITS+1:2];
  assign ready_o   = (state_q == StReady);
  // Clear takes priority over a same-cycle update.
  assign upd_apply = upd_valid_i && ready_o && !clear_i;

  // PC bits outside the index are intentionally ignored (no tags).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i[31:INDEX_BITS+2], pred_pc_i[1:0],
                            upd_pc_i[31:INDEX_BITS+2], upd_pc_i[1:0]};

  // Saturating counter next value for the entry being updated.
  always_comb begin
    upd_cur     = table_q[upd_idx];
    upd_correct = (upd_cur[1] == upd_taken_i);
    upd_new     = upd_cur;
    unique case (upd_cur)
      2'b00: upd_new = upd_correct ? 2'b00 : 2'b01;
      2'b01: upd_new = upd_correct ? 2'b00 : 2'b10;
      2'b10: upd_new = upd_correct ? 2'b11 : 2'b01;
      2'b11: upd_new = upd_correct ? 2'b11 : 2'b10;
      default: upd_new = upd_cur;
    endcase
  end

  // Prediction read with same-cycle forwarding of an applied update.
  always_comb begin
    pred_cnt_o = 2'b00;
    if (ready_o) begin
      if (upd_apply && (upd_idx == pred_idx)) pred_cnt_o = upd_new;
      else                                    pred_cnt_o = table_q[pred_idx];
    end
    pred_taken_o = pred_cnt_o[1];
  end

  // Init sweep / ready FSM and mispredict statistics.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    unique case (state_q)
      StInit: begin
        if (clear_i) begin
          idx_d = '0;
          mis_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
          if (&idx_q) state_d = StReady;
        end
      end
      StReady: begin
        if (clear_i) begin
          state_d = StInit;
          idx_d   = '0;
          mis_d   = '0;
        end else if (upd_apply && !upd_correct && !(&mis_q)) begin
          mis_d = mis_q + 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      idx_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
    end
  end

  // Table storage: sweep writes during init, outcome writes when ready.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      table_q[idx_q] <= INIT_STATE;
    end else if (upd_apply) begin
      table_q[upd_idx] <= upd_new;
    end
  end

  assign mispred_cnt_o = mis_q;

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Direct-mapped table of 2-bit saturating branch counters for the fetch stage.
- Fetch reads it to get a taken/not-taken prediction.
- The resolve stage (EX) writes back each branch's actual outcome.
- The table applies the saturating update internally using the standard 2-bit predictor state encoding.
- It also owns table initialisation after reset or clear, and keeps a misprediction counter for perf monitoring.

Parameters:
- INDEX_BITS, 6, table holds 2**INDEX_BITS entries; index = pc[INDEX_BITS+1:2].
- INIT_STATE, 2'b01, counter value written to every entry during init (weakly not-taken).
- STAT_WIDTH, 16, width of the saturating mispredict counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous request to re-initialise the table and statistics.
- pred_pc_i  input  32  fetch PC to predict.
- pred_taken_o  output  1  predicted direction (counter MSB).
- pred_cnt_o  output  2  counter value for pred_pc_i.
- upd_valid_i  input  1  resolved branch update strobe.
- upd_pc_i  input  32  PC of the resolved branch.
- upd_taken_i  input  1  actual branch outcome.
- ready_o  output  1  table initialised and accepting updates.
- mispred_cnt_o  output  STAT_WIDTH  saturating count of applied updates whose prediction was wrong.

Behaviour:
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = cnt[1].
- FSM states: INIT and READY.
  - reset_n low: state=INIT, sweep index=0, ready_o=0, mispred_cnt_o=0. Async assertion aborts any sweep in progress.
  - INIT: each cycle writes INIT_STATE to entry[sweep index], then index+1.
  - After writing the last entry (index 2**INDEX_BITS-1), move to READY. ready_o=1 from the next cycle.
  - A full sweep takes exactly 2**INDEX_BITS cycles after reset release.
  - READY with clear_i=1: next state INIT, index=0, mispred_cnt_o=0.
  - clear_i during INIT restarts the sweep at index 0.
- Prediction path is combinational, zero latency:
  - pred_cnt_o = entry[pred index]; pred_taken_o = pred_cnt_o[1].
  - While ready_o=0: pred_cnt_o=2'b00 and pred_taken_o=0.
- Update rule: applied only when upd_valid_i=1, ready_o=1 and clear_i=0. Otherwise the update is silently dropped.
  - correct = (entry[upd index][1] == upd_taken_i), evaluated against the current table contents.
  - Next-state mapping:
    - 00: correct -> 00, wrong -> 01.
    - 01: correct -> 00, wrong -> 10.
    - 10: correct -> 11, wrong -> 01.
    - 11: correct -> 11, wrong -> 10.
  - The entry is written at the rising edge.
  - One update per cycle. No back-pressure; the update side never stalls.
- Forwarding: if an update is applied in the same cycle and the pred and upd indices are equal, pred_cnt_o/pred_taken_o show the post-update value. There is no stale read-after-write window.
- Aliasing: only the index bits are used; no tags. PCs that share an index share one counter.
- Statistics: mispred_cnt_o increments by 1 on each applied update with correct=0.
  - It saturates at all-ones and does not wrap.
  - It is cleared by reset or clear_i.
  - Dropped updates do not count.
- Simultaneous clear_i and upd_valid_i in READY: clear wins and the update is dropped.

Test Plan:
1. Release reset with INDEX_BITS=6 -> ready_o=0 for exactly 64 cycles, then 1; every index predicts cnt=01, taken=0.
2. Entry at PC 0x100 (init 01): updates with taken=1 x3 -> cnt sequence 10, 11, 11; mispred_cnt_o = 1, 1, 1. Then taken=0 x3 -> 10, 01, 00; mispred_cnt_o = 2, 3, 3.
3. pred_pc_i = upd_pc_i = 0x40, entry 01, upd_taken_i=1 in the same cycle -> pred_cnt_o=10 and pred_taken_o=1 combinationally that cycle.
4. PCs 0x004 and 0x104 alias (INDEX_BITS=6): update 0x004 taken twice -> prediction for 0x104 reads 11.
5. Assert clear_i in READY together with upd_valid_i -> update dropped, mispred_cnt_o=0, ready_o low for 64 cycles. Then drop reset_n at sweep index 20 -> sweep restarts at 0, 64 more cycles to ready.
6. STAT_WIDTH=4, 20 consecutive mispredicts alternating between two entries -> mispred_cnt_o stops at 15 and does not wrap. Updates issued during INIT leave the table and counter unchanged.
